// File: rtl/ballot_collector.sv
// Three-voter ballot collector: synchronised casts, first-cast-wins, valid/ready hand-off.
// Optional idle timeout lock enabled with `define BALLOT_TIMEOUT_EN.
module ballot_collector #(
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cast_w,
    input  logic               cast_n,
    input  logic               cast_o,
    input  logic               sel_w,
    input  logic               sel_n,
    input  logic               sel_o,
    input  logic               clear,
    input  logic               ballot_ready,
    output logic               w,
    output logic               n,
    output logic               o,
    output logic               ballot_valid,
    output logic [2:0]         voted,
    output logic [COUNT_W-1:0] ballot_count,
    output logic               timed_out
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        LOCKED
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_q, state_n;
    logic [2:0]         cast_s1, cast_s2, cast_s3;
    logic [2:0]         sel_s1, sel_s2;
    logic [2:0]         vote_q, vote_n;
    logic [2:0]         voted_q, voted_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic [2:0]         ev;
    logic [2:0]         fresh;
    logic [2:0]         merged;

    // cast_s3 holds the previous synced cast so a held button fires once
    always_ff @(posedge clk) begin
        if (rst) begin
            cast_s1 <= '0;
            cast_s2 <= '0;
            cast_s3 <= '0;
            sel_s1  <= '0;
            sel_s2  <= '0;
        end else begin
            cast_s1 <= {cast_w, cast_n, cast_o};
            cast_s2 <= cast_s1;
            cast_s3 <= cast_s2;
            sel_s1  <= {sel_w, sel_n, sel_o};
            sel_s2  <= sel_s1;
        end
    end

    assign ev     = cast_s2 & ~cast_s3;
    assign fresh  = ev & ~voted_q;
    assign merged = voted_q | fresh;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q, timer_n;
    logic          tmo_q, tmo_n;
`endif

    always_comb begin
        state_n = state_q;
        vote_n  = vote_q;
        voted_n = voted_q;
        count_n = count_q;
`ifdef BALLOT_TIMEOUT_EN
        timer_n = '0;
        tmo_n   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!clear && (ev != 3'b000)) begin
                    vote_n  = sel_s2 & ev;
                    voted_n = ev;
                    state_n = (ev == 3'b111) ? LOCKED : COLLECT;
                end
            end
            COLLECT: begin
                if (clear) begin
                    vote_n  = '0;
                    voted_n = '0;
                    state_n = IDLE;
                end else begin
                    vote_n  = vote_q | (sel_s2 & fresh);
                    voted_n = merged;
                    if (merged == 3'b111) begin
                        state_n = LOCKED;
                    end
`ifdef BALLOT_TIMEOUT_EN
                    // a vote landing in the expiry cycle restarts the timer
                    else if (fresh == 3'b000 &&
                             timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_n = LOCKED;
                        tmo_n   = 1'b1;
                    end
                    timer_n = (fresh != 3'b000) ? '0 : timer_q + TW'(1);
`endif
                end
            end
            LOCKED: begin
                if (ballot_ready) begin
                    vote_n  = '0;
                    voted_n = '0;
                    count_n = count_q + COUNT_W'(1);
                    state_n = IDLE;
`ifdef BALLOT_TIMEOUT_EN
                    tmo_n   = 1'b0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                vote_n  = '0;
                voted_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vote_q  <= '0;
            voted_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            vote_q  <= vote_n;
            voted_q <= voted_n;
            count_q <= count_n;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            timer_q <= timer_n;
            tmo_q   <= tmo_n;
        end
    end

    assign timed_out = tmo_q;
`else
    assign timed_out = 1'b0;
`endif

    assign w            = vote_q[2];
    assign n            = vote_q[1];
    assign o            = vote_q[0];
    assign voted        = voted_q;
    assign ballot_valid = (state_q == LOCKED);
    assign ballot_count = count_q;

endmodule
